csr_file: RTL and testbench

- Machine-mode CSR responder for the RV32IM single-cycle core.
- Services the CSR read/write requests raised by the decoder's is_csr / csr_read_en / csr_write_en outputs.
- Performs the CSRRW/RS/RC(I) read-modify-write, maintains the cycle/instret counters, and holds trap state (mepc, mcause, mstatus) for trap entry and mret.
- Sits beside the register file; rdata feeds the rd write-back mux.

---
 rtl/csr_file.sv | 208 ++++++++++++++++++++
 tb/tb_csr_file.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR responder for the RV32IM single-cycle core.
// Optional build macro CSR_COUNTERS_EN adds the mcycle/minstret counters and
// their cycle/instret mirrors; without it those addresses read 0 and ignore writes.
module csr_file #(
    parameter logic [31:0] HART_ID  = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL = 32'h4000_1100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_csr,
    input  logic        csr_read_en,
    input  logic        csr_write_en,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  rs1_zimm,
    input  logic        instr_retire,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out
);

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;
`endif

    logic            addr_valid;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] wdata;
    logic            wr_attempt;
    logic            we;
    logic            we_eff;
    logic            unused_ok;

    // Address decode and current-value mux
    always_comb begin
        addr_valid = 1'b1;
        old_val    = '0;
        case (csr_addr)
            ADDR_MSTATUS:  old_val = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            ADDR_MISA:     old_val = MISA_VAL;
            ADDR_MTVEC:    old_val = mtvec_q;
            ADDR_MSCRATCH: old_val = mscratch_q;
            ADDR_MEPC:     old_val = mepc_q;
            ADDR_MCAUSE:   old_val = mcause_q;
            ADDR_MHARTID:  old_val = HART_ID;
            ADDR_MCYCLE, ADDR_CYCLE: begin
`ifdef CSR_COUNTERS_EN
                old_val = mcycle_q[31:0];
`endif
            end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
`ifdef CSR_COUNTERS_EN
                old_val = mcycle_q[63:32];
`endif
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
`ifdef CSR_COUNTERS_EN
                old_val = minstret_q[31:0];
`endif
            end
            ADDR_MINSTRH, ADDR_INSTRETH: begin
`ifdef CSR_COUNTERS_EN
                old_val = minstret_q[63:32];
`endif
            end
            default: addr_valid = 1'b0;
        endcase
    end

    // Read-modify-write value, legality and write enable
    always_comb begin
        src = funct3[2] ? {27'h0, rs1_zimm} : rs1_data;
        case (funct3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = old_val | src;
            default: wdata = old_val & ~src;
        endcase
        wr_attempt  = csr_write_en && ((funct3[1:0] == 2'b01) || (rs1_zimm != 5'd0));
        csr_illegal = is_csr && (!addr_valid
                                 || (wr_attempt && (csr_addr[11:10] == 2'b11))
                                 || (funct3[1:0] == 2'b00));
        we          = is_csr && wr_attempt && !csr_illegal;
        we_eff      = we && !trap_req;
        csr_rdata   = (is_csr && csr_read_en && !csr_illegal) ? old_val : '0;
    end

    // Next-state: mret, then CSR writes, then trap entry overriding both
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (we_eff) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = wdata[3];
                    mstatus_mpie_d = wdata[7];
                end
                ADDR_MTVEC:    mtvec_d    = {wdata[31:2], 2'b00};
                ADDR_MSCRATCH: mscratch_d = wdata;
                ADDR_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
                ADDR_MCAUSE:   mcause_d   = wdata;
                default: ;
            endcase
        end
        if (trap_req) begin
            mepc_d         = {trap_pc[31:2], 2'b00};
            mcause_d       = trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

`ifdef CSR_COUNTERS_EN
    // Counter next-state: a write to one half freezes the other half
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(instr_retire);
        if (we_eff) begin
            case (csr_addr)
                ADDR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wdata};
                ADDR_MCYCLEH:  mcycle_d   = {wdata, mcycle_q[31:0]};
                ADDR_MINSTRET: minstret_d = {minstret_q[63:32], wdata};
                ADDR_MINSTRH:  minstret_d = {wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign unused_ok = ^trap_pc[1:0];
`else
    assign unused_ok = ^{instr_retire, trap_pc[1:0]};
`endif

    // Trap and scratch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b1;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: vector table plus directed trap/mret/reset/counter sequences.
module tb_csr_file;

    localparam logic [31:0] HART = 32'h0000_0007;
    localparam logic [31:0] MISA = 32'h4000_1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_csr, csr_read_en, csr_write_en;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_zimm;
    logic        instr_retire, trap_req, mret;
    logic [31:0] trap_cause, trap_pc;
    logic [31:0] csr_rdata, mtvec_out, mepc_out;
    logic        csr_illegal, mie_out;

    int n_cmp = 0;
    int n_bad = 0;

    csr_file #(.HART_ID(HART), .MISA_VAL(MISA)) dut (
        .clk(clk), .rst(rst), .is_csr(is_csr), .csr_read_en(csr_read_en),
        .csr_write_en(csr_write_en), .funct3(funct3), .csr_addr(csr_addr),
        .rs1_data(rs1_data), .rs1_zimm(rs1_zimm), .instr_retire(instr_retire),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .mtvec_out(mtvec_out),
        .mepc_out(mepc_out), .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string nm, logic rd, logic wr, logic [2:0] f3, logic [11:0] a,
                                logic [31:0] r, logic [4:0] z, logic [31:0] er, logic ei);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a;
        v.rs1 = r; v.zimm = z; v.exp_rdata = er; v.exp_ill = ei;
        return v;
    endfunction

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        is_csr = 0; csr_read_en = 0; csr_write_en = 0; funct3 = 3'b000; csr_addr = 12'h0;
        rs1_data = 0; rs1_zimm = 0; instr_retire = 0; trap_req = 0; trap_cause = 0;
        trap_pc = 0; mret = 0;
    endtask

    task automatic drv(logic rd, logic wr, logic [2:0] f3, logic [11:0] a,
                       logic [31:0] r, logic [4:0] z);
        is_csr = 1; csr_read_en = rd; csr_write_en = wr; funct3 = f3; csr_addr = a;
        rs1_data = r; rs1_zimm = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CSRRS with x0: pure read, checked mid-cycle, then one clock
    task automatic rd_chk(string nm, logic [11:0] a, logic [31:0] exp);
        drv(1, 1, 3'b010, a, 32'h0, 5'd0);
        #1;
        chk32(nm, csr_rdata, exp);
        chk32({nm, "_ill"}, 32'(csr_illegal), 32'h0);
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        chk32("rst_mtvec_out", mtvec_out, 32'h0);
        chk32("rst_mepc_out", mepc_out, 32'h0);
        chk32("rst_mie_out", 32'(mie_out), 32'h0);

        vq.push_back(mk("rd_mstatus",    1, 1, 3'b010, 12'h300, 32'h0,        5'd0,  32'h0000_0080, 0));
        vq.push_back(mk("rd_mhartid",    1, 1, 3'b010, 12'hF14, 32'h0,        5'd0,  HART,          0));
        vq.push_back(mk("rd_misa",       1, 1, 3'b010, 12'h301, 32'h0,        5'd0,  MISA,          0));
        vq.push_back(mk("rw_mscratch",   1, 1, 3'b001, 12'h340, 32'hDEADBEEF, 5'd5,  32'h0,         0));
        vq.push_back(mk("rs_mscratch",   1, 1, 3'b010, 12'h340, 32'h0000000F, 5'd6,  32'hDEADBEEF,  0));
        vq.push_back(mk("rd_mscratch1",  1, 1, 3'b010, 12'h340, 32'h0,        5'd0,  32'hDEADBEEF,  0));
        vq.push_back(mk("rci_mscratch",  1, 1, 3'b111, 12'h340, 32'h0,        5'h0F, 32'hDEADBEEF,  0));
        vq.push_back(mk("rd_mscratch2",  1, 1, 3'b010, 12'h340, 32'h0,        5'd0,  32'hDEADBEE0,  0));
        vq.push_back(mk("rw_mtvec",      1, 1, 3'b001, 12'h305, 32'h80000103, 5'd7,  32'h0,         0));
        vq.push_back(mk("rs_mtvec_x0",   1, 1, 3'b010, 12'h305, 32'hFFFFFFFF, 5'd0,  32'h80000100,  0));
        vq.push_back(mk("rd_mtvec",      1, 1, 3'b010, 12'h305, 32'h0,        5'd0,  32'h80000100,  0));
        vq.push_back(mk("rw_cycle_ro",   1, 1, 3'b001, 12'hC00, 32'h5,        5'd1,  32'h0,         1));
        vq.push_back(mk("rw_mhartid_ro", 1, 1, 3'b001, 12'hF14, 32'h5,        5'd1,  32'h0,         1));
        vq.push_back(mk("rd_unimpl",     1, 1, 3'b010, 12'h7C0, 32'h0,        5'd0,  32'h0,         1));
        vq.push_back(mk("f3_000",        1, 1, 3'b000, 12'h340, 32'h0,        5'd3,  32'h0,         1));
        vq.push_back(mk("f3_100",        1, 1, 3'b100, 12'h340, 32'h0,        5'd3,  32'h0,         1));
        vq.push_back(mk("rd_mscratch3",  1, 1, 3'b010, 12'h340, 32'h0,        5'd0,  32'hDEADBEE0,  0));
        vq.push_back(mk("rw_no_rden",    0, 1, 3'b001, 12'h340, 32'h55,       5'd2,  32'h0,         0));
        vq.push_back(mk("rd_mscratch4",  1, 1, 3'b010, 12'h340, 32'h0,        5'd0,  32'h00000055,  0));
        vq.push_back(mk("rwi_mepc",      1, 1, 3'b101, 12'h341, 32'hFFFFFFFF, 5'h13, 32'h0,         0));
        vq.push_back(mk("rd_mepc",       1, 1, 3'b010, 12'h341, 32'h0,        5'd0,  32'h00000010,  0));
        vq.push_back(mk("rsi_mstatus",   1, 1, 3'b110, 12'h300, 32'h0,        5'd8,  32'h00000080,  0));
        vq.push_back(mk("rd_mstatus2",   1, 1, 3'b010, 12'h300, 32'h0,        5'd0,  32'h00000088,  0));

        foreach (vq[i]) begin
            drv(vq[i].rd, vq[i].wr, vq[i].f3, vq[i].addr, vq[i].rs1, vq[i].zimm);
            #1;
            chk32(vq[i].name, csr_rdata, vq[i].exp_rdata);
            chk32({vq[i].name, "_ill"}, 32'(csr_illegal), 32'(vq[i].exp_ill));
            tick();
            idle();
        end

        // non-CSR instruction must not see read data
        csr_read_en = 1; csr_addr = 12'h340; funct3 = 3'b010;
        #1;
        chk32("not_csr_rdata", csr_rdata, 32'h0);
        chk32("not_csr_ill", 32'(csr_illegal), 32'h0);
        tick();
        idle();

        chk32("mtvec_out", mtvec_out, 32'h80000100);
        chk32("mepc_out_w", mepc_out, 32'h00000010);
        chk32("mie_out_set", 32'(mie_out), 32'h1);

        // trap entry with MIE=1
        trap_req = 1; trap_pc = 32'h106; trap_cause = 32'hB;
        tick();
        idle();
        chk32("trap_mepc_out", mepc_out, 32'h104);
        chk32("trap_mie_out", 32'(mie_out), 32'h0);
        rd_chk("trap_mcause", 12'h342, 32'hB);
        rd_chk("trap_mstatus", 12'h300, 32'h80);

        // mret restores MIE from MPIE
        mret = 1;
        tick();
        idle();
        chk32("mret_mie_out", 32'(mie_out), 32'h1);
        rd_chk("mret_mstatus", 12'h300, 32'h88);

        // trap beats a same-cycle CSRRW mepc
        drv(1, 1, 3'b001, 12'h341, 32'h2000, 5'd4);
        trap_req = 1; trap_pc = 32'h208; trap_cause = 32'h2;
        tick();
        idle();
        chk32("trapwin_mepc_out", mepc_out, 32'h208);
        rd_chk("trapwin_mcause", 12'h342, 32'h2);
        rd_chk("trapwin_mstatus", 12'h300, 32'h80);

        // CSRRW mstatus beats a same-cycle mret
        drv(1, 1, 3'b001, 12'h300, 32'h0, 5'd1);
        mret = 1;
        tick();
        idle();
        rd_chk("mret_vs_wr_mstatus", 12'h300, 32'h0);

        // mret with a write to another CSR: both take effect
        drv(1, 1, 3'b001, 12'h340, 32'h77, 5'd1);
        mret = 1;
        tick();
        idle();
        rd_chk("mret_other_mstatus", 12'h300, 32'h80);
        rd_chk("mret_other_mscratch", 12'h340, 32'h77);

        // reset discards a same-cycle write
        drv(1, 1, 3'b001, 12'h340, 32'h1234, 5'd1);
        rst = 1;
        tick();
        idle();
        rst = 0;
        rd_chk("rstwr_mscratch", 12'h340, 32'h0);
        rd_chk("rstwr_mstatus", 12'h300, 32'h80);
        chk32("rstwr_mepc_out", mepc_out, 32'h0);
        chk32("rstwr_mtvec_out", mtvec_out, 32'h0);

`ifdef CSR_COUNTERS_EN
        do_reset();
        rd_chk("mcycle_0", 12'hB00, 32'd0);
        rd_chk("mcycle_1", 12'hB00, 32'd1);
        rd_chk("cycle_2", 12'hC00, 32'd2);

        // low-to-high carry
        drv(1, 1, 3'b001, 12'hB80, 32'h0, 5'd1);
        tick();
        idle();
        drv(1, 1, 3'b001, 12'hB00, 32'hFFFFFFFE, 5'd1);
        tick();
        idle();
        rd_chk("carry_lo_a", 12'hB00, 32'hFFFFFFFE);
        rd_chk("carry_hi_a", 12'hB80, 32'h0);
        rd_chk("carry_hi_b", 12'hB80, 32'h1);
        rd_chk("carry_lo_b", 12'hB00, 32'h1);
        rd_chk("carry_cycleh", 12'hC80, 32'h1);

        // write to read-only mirror is illegal and leaves the counter alone
        drv(1, 1, 3'b001, 12'hB00, 32'd100, 5'd1);
        tick();
        idle();
        drv(1, 1, 3'b001, 12'hC00, 32'h0, 5'd1);
        #1;
        chk32("ro_cycle_ill", 32'(csr_illegal), 32'h1);
        chk32("ro_cycle_rdata", csr_rdata, 32'h0);
        tick();
        idle();
        rd_chk("ro_cycle_after", 12'hB00, 32'd101);

        // minstret write wins over a same-cycle retire
        drv(1, 1, 3'b001, 12'hB02, 32'd5, 5'd1);
        instr_retire = 1;
        tick();
        idle();
        rd_chk("minstret_wr", 12'hB02, 32'd5);
        instr_retire = 1;
        repeat (3) tick();
        idle();
        rd_chk("instret_cnt", 12'hC02, 32'd8);
        rd_chk("minstreth", 12'hB82, 32'd0);
`else
        rd_chk("nocnt_mcycle", 12'hB00, 32'h0);
        drv(1, 1, 3'b001, 12'hB00, 32'h5, 5'd1);
        #1;
        chk32("nocnt_wr_ill", 32'(csr_illegal), 32'h0);
        chk32("nocnt_wr_rdata", csr_rdata, 32'h0);
        tick();
        idle();
        instr_retire = 1;
        tick();
        idle();
        rd_chk("nocnt_mcycle2", 12'hB00, 32'h0);
        rd_chk("nocnt_instret", 12'hC02, 32'h0);
        rd_chk("nocnt_minstreth", 12'hB82, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
